rgb_pwm_fader: RTL
==================

Name: rgb_pwm_fader

Overview:
Downstream stage of the LED blinker. Takes the three on/off LED requests and drives the physical RGB pins with PWM. Each request is turned into a smooth fade-in/fade-out ramp ("breathing"), and brightness is capped by a global level. Output updates are glitch-free at PWM period boundaries.

Parameters:
PWM_BITS, 8, width of PWM counter and duty values; the PWM period is 2^PWM_BITS clocks.
FADE_DIV, 1024, clocks per fade tick; must be ≥1.
STEP, 1, duty increment/decrement per fade tick; must be ≥1.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  asynchronous, active-low reset (asserted when 0).
in_r  input  1  red on-request from blinker; same clock domain.
in_g  input  1  green on-request.
in_b  input  1  blue on-request.
brightness  input  PWM_BITS  duty ceiling for all channels; sampled on fade ticks.
pwm_r  output  1  red PWM pin drive, registered.
pwm_g  output  1  green PWM pin drive, registered.
pwm_b  output  1  blue PWM pin drive, registered.
fading  output  1  high while any channel is in state UP or DOWN, registered.

Behaviour:
- Reset (rst=0, async): pwm_cnt=0, prescaler=0, every duty_tgt=0, every duty_act=0, every state=OFF, pwm_*=0, fading=0. Reset may occur mid-ramp; on release everything restarts from 0 with no residual duty.
- PWM counter: free-running 0..2^PWM_BITS-1, wraps to 0.
- Prescaler: counts 0..FADE_DIV-1. fade_tick=1 for one cycle when the prescaler equals FADE_DIV-1, then the prescaler wraps to 0.
- Per-channel duty_tgt update, only on fade_tick:
  - in_x=1 and duty_tgt<brightness: duty_tgt = min(duty_tgt+STEP, brightness).
  - in_x=0, or duty_tgt>brightness: duty_tgt = max(duty_tgt-STEP, 0), computed without underflow.
  - Otherwise unchanged.
  - Arithmetic uses PWM_BITS+1 bits internally, so no wrap occurs.
- Per-channel state, updated on the same fade tick from the new duty_tgt, in_x and brightness:
  - OFF: in_x=0 and duty_tgt=0.
  - UP: duty_tgt<ceiling and in_x=1.
  - ON: in_x=1 and duty_tgt=brightness.
  - DOWN: duty_tgt>0 and (in_x=0 or duty_tgt>brightness).
  - An in_x toggle mid-ramp reverses direction from the current duty on the next tick; duty never jumps.
  - in_x=1 with brightness=0 gives state ON with duty 0.
- Shadow load: duty_act <= duty_tgt only on the cycle pwm_cnt = 2^PWM_BITS-1, so a new duty takes effect from the next period's pwm_cnt=0.
- Output: pwm_x <= (pwm_cnt < duty_act), a registered compare with 1-cycle latency.
  - duty_act=0 gives a constant 0.
  - duty_act=2^PWM_BITS-1 gives high for 2^PWM_BITS-1 of each 2^PWM_BITS cycles.
- fading <= OR over channels of (state==UP or state==DOWN), registered.
- Simultaneous fade_tick and shadow-load cycle: duty_act takes the pre-tick duty_tgt; the new value loads at the following period boundary.

Test Plan:
All scenarios use PWM_BITS=4, FADE_DIV=4, STEP=1 (16-clock period, tick every 4 clocks).
1. Reset: hold rst=0 with in_r=1 and brightness=15 -> pwm_*=0 and fading=0. Release rst and run 100 clocks with in_*=0 -> pwm_* stays 0.
2. Fade-in: in_r=1 from reset, brightness=15 -> duty_tgt reaches 15 after 15 ticks (60 clocks); fading=1 during the ramp, 0 afterwards. Then pwm_r is high 15/16 of each period; pwm_g and pwm_b stay 0.
3. Cap: after reaching 15, set brightness=6 -> duty_tgt falls 15→6 over 9 ticks; then pwm_r is high exactly 6 of 16 clocks, starting at the period boundary.
4. Reversal: in_g=1 until duty_tgt=5, then in_g=0 -> the next tick gives 4, then it ramps to 0 with no jump; the state sequence is UP, DOWN, OFF.
5. Glitch-free: change duty_tgt mid-period -> the high-time of the current period is unchanged; the new width first appears in the period starting at pwm_cnt=0.
6. Async reset mid-ramp: assert rst=0 between clock edges at duty 8 -> pwm_* drops to 0 without waiting for a clock edge; after release, duty restarts from 0.

Source files
------------

// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: turns three on/off LED requests into PWM pin drives.
// Each channel ramps its duty up or down by STEP once per fade tick
// ("breathing"), capped by a global brightness. New duties are loaded
// into the comparator only at the end of a PWM period, so pulse widths
// never change mid-period.
module rgb_pwm_fader #(
    parameter int PWM_BITS = 8,
    parameter int FADE_DIV = 1024,
    parameter int STEP     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_r,
    input  logic                in_g,
    input  logic                in_b,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                pwm_r,
    output logic                pwm_g,
    output logic                pwm_b,
    output logic                fading
);

    localparam int PRE_W   = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    // A step larger than the whole duty range behaves like a full-range step.
    localparam int STEP_CL = (STEP > (1 << PWM_BITS)) ? (1 << PWM_BITS) : STEP;
    localparam logic [PWM_BITS:0] STEP_W  = (PWM_BITS+1)'(STEP_CL);
    localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(FADE_DIV - 1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_UP   = 2'd1,
        ST_ON   = 2'd2,
        ST_DOWN = 2'd3
    } state_t;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PRE_W-1:0]    prescaler;
    logic                fade_tick;
    logic                period_end;
    logic [2:0]          req;

    logic [PWM_BITS-1:0] duty_tgt  [3];
    logic [PWM_BITS-1:0] tgt_nxt   [3];
    logic [PWM_BITS-1:0] duty_act  [3];
    state_t              state     [3];
    state_t              state_nxt [3];
    logic [2:0]          pwm_nxt;
    logic                fading_nxt;

    // Duty + STEP, clamped to the ceiling; the extra bit keeps the sum from wrapping.
    function automatic logic [PWM_BITS-1:0] sat_inc(input logic [PWM_BITS-1:0] d,
                                                    input logic [PWM_BITS-1:0] ceil_v);
        logic [PWM_BITS:0] sum;
        sum = {1'b0, d} + STEP_W;
        if (sum > {1'b0, ceil_v})
            return ceil_v;
        return sum[PWM_BITS-1:0];
    endfunction

    // Duty - STEP, floored at zero without underflow.
    function automatic logic [PWM_BITS-1:0] sat_dec(input logic [PWM_BITS-1:0] d);
        logic [PWM_BITS:0] diff;
        if ({1'b0, d} < STEP_W)
            return '0;
        diff = {1'b0, d} - STEP_W;
        return diff[PWM_BITS-1:0];
    endfunction

    // Ramp state derived from the freshly updated duty, request and ceiling.
    function automatic state_t classify(input logic [PWM_BITS-1:0] d,
                                        input logic                on,
                                        input logic [PWM_BITS-1:0] ceil_v);
        if (!on && d == '0)
            return ST_OFF;
        if (on && d < ceil_v)
            return ST_UP;
        if (on && d == ceil_v)
            return ST_ON;
        return ST_DOWN;
    endfunction

    assign req        = {in_b, in_g, in_r};
    assign fade_tick  = (prescaler == PRE_MAX);
    assign period_end = &pwm_cnt;

    // Free-running PWM counter and fade-tick prescaler.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt   <= '0;
            prescaler <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (fade_tick)
                prescaler <= '0;
            else
                prescaler <= prescaler + 1'b1;
        end
    end

    // Next duty target and ramp state; both only move on a fade tick.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            tgt_nxt[i]   = duty_tgt[i];
            state_nxt[i] = state[i];
            if (fade_tick) begin
                if (req[i] && (duty_tgt[i] < brightness))
                    tgt_nxt[i] = sat_inc(duty_tgt[i], brightness);
                else if (!req[i] || (duty_tgt[i] > brightness))
                    tgt_nxt[i] = sat_dec(duty_tgt[i]);
                state_nxt[i] = classify(tgt_nxt[i], req[i], brightness);
            end
        end
    end

    // Duty target and ramp state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                duty_tgt[i] <= '0;
                state[i]    <= ST_OFF;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                duty_tgt[i] <= tgt_nxt[i];
                state[i]    <= state_nxt[i];
            end
        end
    end

    // Shadow load at the last count of a period; on a coinciding fade tick
    // this takes the pre-tick target and the new one waits a full period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++)
                duty_act[i] <= '0;
        end else if (period_end) begin
            for (int i = 0; i < 3; i++)
                duty_act[i] <= duty_tgt[i];
        end
    end

    // Compare results and the any-channel-ramping flag.
    always_comb begin
        pwm_nxt    = '0;
        fading_nxt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pwm_nxt[i] = (pwm_cnt < duty_act[i]);
            if (state[i] == ST_UP || state[i] == ST_DOWN)
                fading_nxt = 1'b1;
        end
    end

    // Registered pin drives and fading flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_r  <= 1'b0;
            pwm_g  <= 1'b0;
            pwm_b  <= 1'b0;
            fading <= 1'b0;
        end else begin
            pwm_r  <= pwm_nxt[0];
            pwm_g  <= pwm_nxt[1];
            pwm_b  <= pwm_nxt[2];
            fading <= fading_nxt;
        end
    end

endmodule
